jtag_dr_tx: RTL and testbench
=============================

// Module: jtag_dr_tx
// PURPOSE
//  Return path of the JTAGG debug-register link: the SoC queues 32-bit words, a JTAG host reads them
//  out on TDO by scanning DR with ER1 (IR 0x32) selected. ER2 (IR 0x38) scans return a status word.
//  Sits beside the existing TDI-side DR capture logic in the FPGA top, clocked by clk48m.
//  JTCK is sampled, not used as a clock.
// PARAMETERS
//  WIDTH        32    DR length in bits, shifted LSB first
//  FIFO_DEPTH   2     data words buffered for ER1, power of 2, >=2
//  SYNC_STAGES  2     synchroniser flops on JTCK/JSHIFT/JCE1/JCE2/JUPDATE/JRSTN
//  SIGNATURE    8'hA5 value returned in status[31:24]
// PORTS
//  clk          in   1      system clock (clk48m). Only clock of the block.
//  rstn         in   1      asynchronous active-low reset
//  jtck         in   1      JTAGG JTCK, asynchronous
//  jshift       in   1      JTAGG JSHIFT
//  jce1         in   1      JTAGG JCE1 (ER1 selected, capture/shift)
//  jce2         in   1      JTAGG JCE2 (ER2 selected, capture/shift)
//  jupdate      in   1      JTAGG JUPDATE
//  jrstn        in   1      JTAGG JRSTN, TAP test-logic-reset (active low)
//  tx_data      in   WIDTH  word from SoC
//  tx_valid     in   1      tx_data valid
//  tx_ready     out  1      FIFO not full. Push when tx_valid&&tx_ready.
//  jtdo1        out  1      to JTAGG JTDO1 (ER1)
//  jtdo2        out  1      to JTAGG JTDO2 (ER2)
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  words queued
//  underrun     out  1      sticky: ER1 captured while FIFO empty
// BEHAVIOUR
//  - Reset (rstn=0, async): FIFO empty, shift reg 0, jtdo1=jtdo2=0, tx_ready=1, fifo_level=0, underrun=0.
//    Synchronisers are cleared, so no edge is detected on release.
//  - All J* inputs pass through SYNC_STAGES flops plus one history flop.
//    tick = synced jtck 0->1. Every JTAG action below happens only on a tick cycle, using synced values.
//  - TCK limit: JTCK high and low each >= SYNC_STAGES+2 clk cycles (about 6 MHz max at 48 MHz).
//  - ce = jce1|jce2. A capture is a tick with ce=1 where ce was 0 at the previous tick.
//    - On capture, chain <= jce2.
//    - If jce1 and FIFO not empty: sr <= FIFO head, pend <= 1.
//    - If jce1 and FIFO empty: sr <= 0, underrun <= 1, pend <= 0.
//    - If jce2: sr <= {SIGNATURE, 20'h0, underrun, fifo_level(3b zero-ext)}, then underrun <= 0 on the same tick.
//  - Shift: tick with ce=1, jshift=1, and not a capture: sr <= {1'b0, sr[WIDTH-1:1]}.
//  - jtdo1 = jtdo2 = registered sr[0]. It updates in the clk cycle after the tick, well before the next JTCK rise.
//  - Update: tick with jupdate=1. If pend=1: pop the FIFO head, pend <= 0. The word is consumed only on a completed scan.
//    A scan longer than WIDTH shifts in zeros; a shorter scan still pops.
//  - jrstn synced low: sr <= 0, pend <= 0, chain <= 0. The FIFO and underrun are not touched, so an aborted scan loses no data.
//  - FIFO: registered level; tx_ready = (fifo_level != FIFO_DEPTH).
//    - A push and a pop in the same cycle leave the level unchanged, with order preserved.
//    - A push while full is not accepted. tx_data must be held until tx_ready.
//    - A pop cannot occur while empty, since pend implies an entry.
//    - The pointers wrap modulo FIFO_DEPTH.
//  - rstn asserted mid-scan: immediate reset. The host sees zeros for the remainder of the scan.
// TESTING
//  1. Push 32'hDEADBEEF, then ER1 capture, 32 shifts, update -> TDO bits LSB first = DEADBEEF; fifo_level 1->0.
//  2. Empty FIFO, ER1 scan -> 32 zero bits, underrun=1. Then ER2 scan -> 32'hA5000008, and underrun=0 afterward.
//  3. Push 0x1,0x2,0x3 (depth 2) -> tx_ready=0 after 2nd push. 3rd push is accepted after the first scan.
//     Three scans then return 1,2,3 in order.
//  4. Push 0x55, ER1 capture + 5 shifts, pulse jrstn low -> no pop, fifo_level=1. Next full scan returns 0x55.
//  5. rstn low at shift bit 10 -> jtdo1=0, fifo_level=0, tx_ready=1. Next ER1 scan returns 0 with underrun=1.
//  6. Level 1 with a push coinciding with a pop -> fifo_level stays 1. Next scan returns the pushed word.
//     Run all of 1-6 with TCK at the minimum legal period and at 4x that period.

Source files
------------

// File: rtl/jtag_dr_tx.sv
// jtag_dr_tx: return path of the JTAGG debug-register link.
// The SoC queues WIDTH-bit words in a small FIFO. A JTAG host drains them by
// scanning DR with ER1 selected, and reads a status word by scanning with ER2.
// JTCK and the other JTAGG strobes are oversampled on clk; nothing here is
// clocked by JTCK.
module jtag_dr_tx #(
    parameter int         WIDTH       = 32,
    parameter int         FIFO_DEPTH  = 2,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] SIGNATURE   = 8'hA5,
    localparam int        LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             jtck,
    input  logic             jshift,
    input  logic             jce1,
    input  logic             jce2,
    input  logic             jupdate,
    input  logic             jrstn,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             jtdo1,
    output logic             jtdo2,
    output logic [LVL_W-1:0] fifo_level,
    output logic             underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Bit positions of the JTAGG strobes inside the synchroniser vector.
    localparam int J_TCK    = 0;
    localparam int J_SHIFT  = 1;
    localparam int J_CE1    = 2;
    localparam int J_CE2    = 3;
    localparam int J_UPDATE = 4;
    localparam int J_RSTN   = 5;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [5:0] r_sync [SYNC_STAGES];
    logic       r_tck_hist;

    logic [5:0] w_sync;
    logic       w_s_tck;
    logic       w_s_shift;
    logic       w_s_ce1;
    logic       w_s_ce2;
    logic       w_s_update;
    logic       w_s_jrstn;

    // Bring all JTAGG strobes through the same flop chain so they stay aligned.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_tck_hist <= 1'b0;
        end else begin
            r_sync[0] <= {jrstn, jupdate, jce2, jce1, jshift, jtck};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_tck_hist <= r_sync[SYNC_STAGES-1][J_TCK];
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_s_tck    = w_sync[J_TCK];
    assign w_s_shift  = w_sync[J_SHIFT];
    assign w_s_ce1    = w_sync[J_CE1];
    assign w_s_ce2    = w_sync[J_CE2];
    assign w_s_update = w_sync[J_UPDATE];
    assign w_s_jrstn  = w_sync[J_RSTN];

    // ------------------------------------------------------------------
    // JTAG event decode (all qualified by the JTCK rising-edge tick)
    // ------------------------------------------------------------------
    logic w_tick;
    logic w_ce;
    logic w_capture;
    logic w_shift;
    logic w_pop;
    logic r_ce_prev;

    assign w_tick    = w_s_tck & ~r_tck_hist;
    assign w_ce      = w_s_ce1 | w_s_ce2;
    assign w_capture = w_tick & w_s_jrstn & w_ce & ~r_ce_prev;
    assign w_shift   = w_tick & w_s_jrstn & w_ce & w_s_shift & ~w_capture;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_fifo_empty;
    logic [WIDTH-1:0] w_head;

    assign tx_ready     = (r_level != LVL_W'(FIFO_DEPTH));
    assign w_push       = tx_valid & tx_ready;
    assign w_fifo_empty = (r_level == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign fifo_level   = r_level;

    // Storage for queued words.
    // NOTE: the data array has no reset; the level counter alone decides
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // Pointers and level; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_sr;
    logic             r_pend;
    logic             r_underrun;
    logic             r_tdo;
    logic [WIDTH-1:0] w_status;

    // A word leaves the FIFO only when a scan that loaded it reaches Update-DR.
    assign w_pop = w_tick & w_s_jrstn & w_s_update & r_pend;

    // Status word captured by ER2: signature, sticky underrun, queue depth.
    // NOTE: every signal driven from always_comb receives a default first,
    // so no path through the block can leave it holding a value (no latch).
    always_comb begin
        w_status                  = '0;
        w_status[WIDTH-1 -: 8]    = SIGNATURE;
        w_status[3]               = r_underrun;
        w_status[2:0]             = 3'(r_level);
    end

    // Capture / shift / update / TAP-reset handling of the scan register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sr       <= '0;
            r_pend     <= 1'b0;
            r_underrun <= 1'b0;
            r_ce_prev  <= 1'b0;
        end else if (w_tick) begin
            r_ce_prev <= w_ce;
            if (!w_s_jrstn) begin
                // TAP reset abandons the scan but keeps the queued data.
                r_sr   <= '0;
                r_pend <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_pend <= 1'b0;
                end
                if (w_capture) begin
                    if (w_s_ce2) begin
                        r_sr       <= w_status;
                        r_underrun <= 1'b0;
                        r_pend     <= 1'b0;
                    end else if (!w_fifo_empty) begin
                        r_sr   <= w_head;
                        r_pend <= 1'b1;
                    end else begin
                        r_sr       <= '0;
                        r_underrun <= 1'b1;
                        r_pend     <= 1'b0;
                    end
                end else if (w_shift) begin
                    r_sr <= {1'b0, r_sr[WIDTH-1:1]};
                end
            end
        end
    end

    // Register the outgoing bit; it settles one clk after the tick, long
    // before the host's next JTCK rise. JTAGG picks JTDO1 or JTDO2 by its own
    // instruction register, so both pins carry the same bit and the selected
    // chain needs no storage here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tdo <= 1'b0;
        end else begin
            r_tdo <= r_sr[0];
        end
    end

    assign jtdo1    = r_tdo;
    assign jtdo2    = r_tdo;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_jtag_dr_tx.sv
// Directed testbench for jtag_dr_tx: drives JTAGG strobes at a programmable
// JTCK half-period (in clk cycles) and compares scanned words with
// hand-computed values.
module tb_jtag_dr_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        jtck;
    logic        jshift;
    logic        jce1;
    logic        jce2;
    logic        jupdate;
    logic        jrstn;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        jtdo1;
    logic        jtdo2;
    logic [1:0]  fifo_level;
    logic        underrun;

    int n_assert = 0;
    int n_fail   = 0;
    int half     = 4;

    logic [31:0] w1;
    logic [31:0] w2;
    logic [1:0]  t_dummy;

    jtag_dr_tx dut (
        .clk        (clk),
        .rstn       (rstn),
        .jtck       (jtck),
        .jshift     (jshift),
        .jce1       (jce1),
        .jce2       (jce2),
        .jupdate    (jupdate),
        .jrstn      (jrstn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .jtdo1      (jtdo1),
        .jtdo2      (jtdo2),
        .fifo_level (fifo_level),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One JTCK period; entered and left on a clk falling edge.
    // tdo returns {jtdo2, jtdo1} sampled just before the JTCK rise.
    task automatic jtick(input logic c1, input logic c2, input logic sh,
                         input logic up, input logic jr, output logic [1:0] tdo);
        jtck    = 1'b0;
        jce1    = c1;
        jce2    = c2;
        jshift  = sh;
        jupdate = up;
        jrstn   = jr;
        repeat (half) @(negedge clk);
        tdo  = {jtdo2, jtdo1};
        jtck = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    // Capture plus nshift shift ticks; bit i is sampled before shift tick i.
    task automatic scan_part(input logic er2, input int nshift,
                             output logic [31:0] o1, output logic [31:0] o2);
        logic [1:0] t;
        o1 = '0;
        o2 = '0;
        jtick(~er2, er2, 1'b0, 1'b0, 1'b1, t);
        for (int i = 0; i < nshift; i++) begin
            jtick(~er2, er2, 1'b1, 1'b0, 1'b1, t);
            o1[i] = t[0];
            o2[i] = t[1];
        end
    endtask

    // Exit1, Update, idle. With do_push, a word is pushed in the exact clk
    // cycle the update tick pops (tick lands two clk edges after the JTCK rise
    // has crossed two synchroniser stages).
    task automatic scan_end(input bit do_push, input logic [31:0] d);
        logic [1:0] t;
        jtick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
        if (!do_push) begin
            jtick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t);
        end else begin
            jtck    = 1'b0;
            jupdate = 1'b1;
            repeat (half) @(negedge clk);
            jtck = 1'b1;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = d;
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b0;
            chk("t6_level_push_pop", 32'(fifo_level), 32'd1);
            repeat (half - 2) @(negedge clk);
        end
        jtick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
    endtask

    task automatic scan(input logic er2, output logic [31:0] o1, output logic [31:0] o2);
        scan_part(er2, 32, o1, o2);
        scan_end(1'b0, 32'h0);
    endtask

    // Single-cycle push offer; entered on a falling edge.
    task automatic push(input logic [31:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        rstn     = 1'b0;
        jtck     = 1'b0;
        jshift   = 1'b0;
        jce1     = 1'b0;
        jce2     = 1'b0;
        jupdate  = 1'b0;
        jrstn    = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;

        for (int p = 0; p < 2; p++) begin
            half = (p == 0) ? 4 : 16;

            // Reset state
            rstn = 1'b0;
            repeat (3) @(negedge clk);
            chk("rst_level",    32'(fifo_level), 32'd0);
            chk("rst_tx_ready", 32'(tx_ready),   32'd1);
            chk("rst_jtdo1",    32'(jtdo1),      32'd0);
            chk("rst_jtdo2",    32'(jtdo2),      32'd0);
            chk("rst_underrun", 32'(underrun),   32'd0);
            rstn = 1'b1;
            repeat (3) @(negedge clk);

            // 1: single word out through ER1
            push(32'hDEADBEEF);
            chk("t1_level_before", 32'(fifo_level), 32'd1);
            scan(1'b0, w1, w2);
            chk("t1_word_tdo1",    w1, 32'hDEADBEEF);
            chk("t1_word_tdo2",    w2, 32'hDEADBEEF);
            chk("t1_level_after",  32'(fifo_level), 32'd0);
            chk("t1_underrun",     32'(underrun),   32'd0);

            // 2: underrun then status read
            scan(1'b0, w1, w2);
            chk("t2_empty_word",   w1, 32'h0);
            chk("t2_underrun_set", 32'(underrun), 32'd1);
            scan(1'b1, w1, w2);
            chk("t2_status_tdo2",  w2, 32'hA5000008);
            chk("t2_status_tdo1",  w1, 32'hA5000008);
            chk("t2_underrun_clr", 32'(underrun), 32'd0);

            // 3: fill to depth, refused push, ordering
            push(32'h1);
            push(32'h2);
            chk("t3_full_ready", 32'(tx_ready),   32'd0);
            chk("t3_full_level", 32'(fifo_level), 32'd2);
            push(32'h3);
            chk("t3_refused_level", 32'(fifo_level), 32'd2);
            scan(1'b0, w1, w2);
            chk("t3_word1", w1, 32'h1);
            chk("t3_ready_after_pop", 32'(tx_ready), 32'd1);
            push(32'h3);
            chk("t3_level_refill", 32'(fifo_level), 32'd2);
            scan(1'b0, w1, w2);
            chk("t3_word2", w1, 32'h2);
            scan(1'b0, w1, w2);
            chk("t3_word3", w1, 32'h3);
            chk("t3_level_empty", 32'(fifo_level), 32'd0);

            // 4: aborted scan via TAP reset keeps the word
            push(32'h55);
            scan_part(1'b0, 5, w1, w2);
            jtick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t_dummy);
            jtick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t_dummy);
            chk("t4_level_kept", 32'(fifo_level), 32'd1);
            chk("t4_tdo_cleared", 32'(jtdo1), 32'd0);
            scan(1'b0, w1, w2);
            chk("t4_word", w1, 32'h55);
            chk("t4_level_after", 32'(fifo_level), 32'd0);

            // 5: system reset in the middle of a scan
            push(32'h00000400);
            scan_part(1'b0, 10, w1, w2);
            jtck   = 1'b0;
            jce1   = 1'b0;
            jshift = 1'b0;
            @(negedge clk);
            chk("t5_bit10_before_rst", 32'(jtdo1), 32'd1);
            rstn = 1'b0;
            #1;
            chk("t5_rst_jtdo1", 32'(jtdo1),      32'd0);
            chk("t5_rst_jtdo2", 32'(jtdo2),      32'd0);
            chk("t5_rst_level", 32'(fifo_level), 32'd0);
            chk("t5_rst_ready", 32'(tx_ready),   32'd1);
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            repeat (3) @(negedge clk);
            scan(1'b0, w1, w2);
            chk("t5_word_after_rst", w1, 32'h0);
            chk("t5_underrun", 32'(underrun), 32'd1);
            scan(1'b1, w1, w2);
            chk("t5_status", w2, 32'hA5000008);

            // 6: push coinciding with pop at level 1
            push(32'h0000000A);
            chk("t6_level_before", 32'(fifo_level), 32'd1);
            scan_part(1'b0, 32, w1, w2);
            scan_end(1'b1, 32'h0000000B);
            chk("t6_word_a", w1, 32'h0000000A);
            chk("t6_level_after", 32'(fifo_level), 32'd1);
            scan(1'b0, w1, w2);
            chk("t6_word_b", w1, 32'h0000000B);
            chk("t6_level_empty", 32'(fifo_level), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
